retire_stream_gen: RTL and testbench
====================================

# retire_stream_gen

Synthesizable generator that drives the writeback retire interface (valid / stall / instruction) of the pipelined RISC-V CPU's writeback stage. It stands in for the pipeline so that retire-side consumers (cycle and retire monitors, performance counters) can be exercised standalone. It also keeps expected per-class retirement totals for cross-checking. It sits in the verification harness in place of the core's WB-stage outputs.

## Interface
Parameters:
- NOP_PERIOD, 8: non-NOP retirements between inserted NOP bubbles (only used with RETIRE_GEN_NOP_EN)
- LFSR_DEFAULT_SEED, 16'hACE1: seed substituted when stall_seed_i is zero

Ports:
- clk_i  input  1  clock; all logic on rising edge
- reset_ni  input  1  synchronous, active-low reset
- start_i  input  1  begin a run; sampled only in IDLE
- num_instr_i  input  16  non-NOP retirements in the run; latched at start
- stall_seed_i  input  16  LFSR seed; latched at start
- stall_thresh_i  input  4  stall when lfsr[3:0] < thresh; 0 means never stall; latched at start
- valid_wb_o  output  1  WB stage holds an instruction
- stall_wb_o  output  1  WB stage stalled this cycle
- instr_wb_o  output  32  instruction in WB
- busy_o  output  1  run in progress
- done_o  output  1  one-cycle pulse at end of run
- exp_retire_o, exp_alu_o, exp_branch_o, exp_load_o, exp_store_o  output  32 each  expected non-NOP retirement totals per class

## Operation
- States: IDLE, RUN, DONE.
  - IDLE to RUN on start_i.
  - RUN to DONE on the retirement that makes the remaining count zero, or immediately if num_instr_i == 0.
  - DONE to IDLE unconditionally.
- Retirement is a cycle with valid_wb_o & ~stall_wb_o.
- Class table (idx 0..8), with opcodes:
  - R 0110011, I-ALU 0010011, AUIPC 0010111, LUI 0110111 (ALU)
  - B 1100011, JAL 1101111, JALR 1100111 (branch)
  - LOAD 0000011
  - STORE 0100011
- idx advances (mod 9) on each non-NOP retirement.
- instr_wb_o[6:0] = table[idx]. Bits [31:7] come from lfsr[15:0] replicated, captured when the instruction is launched. The result must never equal NOP 32'h00000013.
- stall_wb_o = (state == RUN) & valid_wb_o & (lfsr[3:0] < thresh).
  - The LFSR is a 16-bit Galois LFSR, taps 16'hB400, advancing every RUN cycle.
  - A seed of 0 is replaced by LFSR_DEFAULT_SEED.
- While stall_wb_o is high, instr_wb_o and valid_wb_o hold their values.
- A new instruction is presented in the cycle after each retirement.
- exp_* counters increment on each non-NOP retirement per class. They clear on start and hold after DONE until the next start.
- start_i is ignored while busy_o is high.

## Timing
- Reset value of every output is 0: valid, stall, instr, busy, done, all exp_* counters. State goes to IDLE.
- Reset mid-run aborts the run immediately, with no done_o pulse.
- start_i sampled high at edge k:
  - busy_o = 1 and valid_wb_o = 1 from cycle k+1.
  - With no stalls, retirements occur in cycles k+1 .. k+N.
- done_o = 1 and busy_o = 0 in the cycle after the final retirement. valid_wb_o = 0 in that same cycle.
- If num_instr_i == 0: done_o in cycle k+1 with no valid cycle.
- Counters are 32-bit and wrap modulo 2^32. The remaining count is 16-bit and never underflows.
- Forward progress is guaranteed for every thresh value, because lfsr[3:0] == 15 recurs.

## Configuration
- RETIRE_GEN_NOP_EN defined: after every NOP_PERIOD non-NOP retirements, one NOP (32'h00000013, valid = 1) is presented and must itself retire.
  - It does not advance idx, the remaining count, or any exp_* counter.
  - A NOP is never inserted after the final instruction.
- Undefined: no NOPs are generated.

## Structure
- Shared package retire_gen_pkg holds:
  - opcode localparams and NOP_INSTR
  - the state enum
  - the class table
- Sub-module lfsr16 (seed load, enable, 16-bit state output).

## Test plan
- num=9, thresh=0, macro off, start at edge k → 9 consecutive retirements in cycles k+1..k+9; opcodes in table order; done_o in cycle k+10; exp_alu=4, exp_branch=3, exp_load=1, exp_store=1, exp_retire=9.
- Same stimulus with RETIRE_GEN_NOP_EN and NOP_PERIOD=8 → 10 valid cycles; the 9th presented instruction is 32'h00000013; exp_retire=9.
- num=20, thresh=12, seed=16'h1234 → stall cycles occur; instr_wb_o stable across every stall; exactly 20 non-NOP retirements; done_o pulses once.
- num=0 → done_o at k+1, valid_wb_o never high, all exp_* counters = 0.
- reset_ni low in the middle of a num=50 run → next cycle all outputs 0 and state IDLE; a later start runs cleanly.
- start_i pulsed while busy → ignored; the run completes with its original num_instr_i.

Source files
------------

// File: rtl/retire_gen_pkg.sv
// Shared definitions for the retire stream generator: opcodes, FSM states
// and the instruction-class table walked by the generator.
package retire_gen_pkg;

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;

   localparam logic [31:0] NOP_INSTR   = 32'h00000013;
   localparam logic [3:0]  LAST_IDX    = 4'd8;
   localparam int          NUM_CLASSES = 4;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   typedef enum logic [1:0] {
      CLS_ALU    = 2'd0,
      CLS_BRANCH = 2'd1,
      CLS_LOAD   = 2'd2,
      CLS_STORE  = 2'd3
   } class_t;

   function automatic logic [6:0] class_opcode(input logic [3:0] idx);
      logic [6:0] op;
      case (idx)
         4'd0:    op = OP_R;
         4'd1:    op = OP_IMM;
         4'd2:    op = OP_AUIPC;
         4'd3:    op = OP_LUI;
         4'd4:    op = OP_BRANCH;
         4'd5:    op = OP_JAL;
         4'd6:    op = OP_JALR;
         4'd7:    op = OP_LOAD;
         default: op = OP_STORE;
      endcase
      return op;
   endfunction

   function automatic class_t class_of(input logic [3:0] idx);
      class_t cls;
      if (idx <= 4'd3)      cls = CLS_ALU;
      else if (idx <= 4'd6) cls = CLS_BRANCH;
      else if (idx == 4'd7) cls = CLS_LOAD;
      else                  cls = CLS_STORE;
      return cls;
   endfunction

   // A non-zero LFSR never yields all-zero upper bits, so the fix-up below
   // only keeps the "never a NOP" property local to this function.
   function automatic logic [31:0] build_instr(input logic [6:0] op, input logic [15:0] rnd);
      logic [31:0] w;
      w = {rnd[8:0], rnd, op};
      if (w == NOP_INSTR) w[31] = 1'b1;
      return w;
   endfunction

endpackage

// File: rtl/lfsr16.sv
// 16-bit Galois LFSR (taps 16'hB400) with synchronous seed load and advance enable.
module lfsr16 #(
   parameter logic [15:0] RESET_VALUE = 16'hACE1
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        load,
   input  logic        en,
   input  logic [15:0] seed,
   output logic [15:0] state
);

   localparam logic [15:0] TAPS = 16'hB400;

   logic [15:0] state_reg;
   logic [15:0] state_next;

   always_comb begin
      state_next = state_reg;
      if (load)
         state_next = seed;
      else if (en)
         state_next = {1'b0, state_reg[15:1]} ^ (state_reg[0] ? TAPS : 16'h0000);
   end

   always_ff @(posedge clk) begin
      if (!reset_n)
         state_reg <= RESET_VALUE;
      else
         state_reg <= state_next;
   end

   assign state = state_reg;

endmodule

// File: rtl/retire_stream_gen.sv
// Drives a synthetic WB-stage retire stream (valid/stall/instr) and keeps
// per-class retirement totals. Define RETIRE_GEN_NOP_EN to insert NOP bubbles.
module retire_stream_gen
   import retire_gen_pkg::*;
#(
   parameter int          NOP_PERIOD        = 8,
   parameter logic [15:0] LFSR_DEFAULT_SEED = 16'hACE1
) (
   input  logic        clk_i,
   input  logic        reset_ni,
   input  logic        start_i,
   input  logic [15:0] num_instr_i,
   input  logic [15:0] stall_seed_i,
   input  logic [3:0]  stall_thresh_i,
   output logic        valid_wb_o,
   output logic        stall_wb_o,
   output logic [31:0] instr_wb_o,
   output logic        busy_o,
   output logic        done_o,
   output logic [31:0] exp_retire_o,
   output logic [31:0] exp_alu_o,
   output logic [31:0] exp_branch_o,
   output logic [31:0] exp_load_o,
   output logic [31:0] exp_store_o
);

`ifdef RETIRE_GEN_NOP_EN
   localparam bit NOP_EN = 1'b1;
`else
   localparam bit NOP_EN = 1'b0;
`endif

   state_t      state_reg, state_next;
   logic [15:0] rem_reg;
   logic [3:0]  thresh_reg;
   logic [3:0]  idx_reg;
   logic [15:0] nop_cnt_reg;
   logic        nop_reg;
   logic        valid_reg;
   logic [31:0] instr_reg;
   logic [31:0] retire_cnt_reg;
   logic [31:0] cls_cnt_reg [NUM_CLASSES];

   logic [15:0] lfsr_state;
   logic [15:0] eff_seed;
   logic        start_fire;
   logic        stall;
   logic        retire;
   logic        real_retire;
   logic        last_retire;
   logic        insert_nop;
   logic [3:0]  idx_adv;
   logic [3:0]  launch_idx;

   assign eff_seed   = (stall_seed_i == 16'h0000) ? LFSR_DEFAULT_SEED : stall_seed_i;
   assign start_fire = (state_reg == ST_IDLE) & start_i;

   lfsr16 #(
      .RESET_VALUE (LFSR_DEFAULT_SEED)
   ) u_lfsr (
      .clk     (clk_i),
      .reset_n (reset_ni),
      .load    (start_fire),
      .en      (state_reg == ST_RUN),
      .seed    (eff_seed),
      .state   (lfsr_state)
   );

   // FSM: state register
   always_ff @(posedge clk_i) begin
      if (!reset_ni)
         state_reg <= ST_IDLE;
      else
         state_reg <= state_next;
   end

   // FSM: next state
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         ST_IDLE: if (start_i) state_next = (num_instr_i == 16'd0) ? ST_DONE : ST_RUN;
         ST_RUN:  if (last_retire) state_next = ST_DONE;
         ST_DONE: state_next = ST_IDLE;
         default: state_next = ST_IDLE;
      endcase
   end

   // FSM: outputs
   always_comb begin
      busy_o     = (state_reg == ST_RUN);
      done_o     = (state_reg == ST_DONE);
      stall_wb_o = (state_reg == ST_RUN) & valid_reg & (lfsr_state[3:0] < thresh_reg);
   end

   assign stall       = stall_wb_o;
   assign retire      = (state_reg == ST_RUN) & valid_reg & ~stall;
   assign real_retire = retire & ~nop_reg;
   assign last_retire = real_retire & (rem_reg == 16'd1);
   assign insert_nop  = NOP_EN & real_retire & ~last_retire
                        & (nop_cnt_reg == 16'(NOP_PERIOD - 1));
   assign idx_adv     = (idx_reg == LAST_IDX) ? 4'd0 : idx_reg + 4'd1;
   // After a NOP retires the class index already points at the next entry.
   assign launch_idx  = nop_reg ? idx_reg : idx_adv;

   always_ff @(posedge clk_i) begin
      if (!reset_ni) begin
         rem_reg        <= '0;
         thresh_reg     <= '0;
         idx_reg        <= '0;
         nop_cnt_reg    <= '0;
         nop_reg        <= 1'b0;
         valid_reg      <= 1'b0;
         instr_reg      <= '0;
         retire_cnt_reg <= '0;
         for (int c = 0; c < NUM_CLASSES; c++) cls_cnt_reg[c] <= '0;
      end else if (start_fire) begin
         rem_reg        <= num_instr_i;
         thresh_reg     <= stall_thresh_i;
         idx_reg        <= '0;
         nop_cnt_reg    <= '0;
         nop_reg        <= 1'b0;
         retire_cnt_reg <= '0;
         for (int c = 0; c < NUM_CLASSES; c++) cls_cnt_reg[c] <= '0;
         valid_reg      <= (num_instr_i != 16'd0);
         instr_reg      <= (num_instr_i != 16'd0) ? build_instr(class_opcode(4'd0), eff_seed) : '0;
      end else if (retire) begin
         nop_reg <= insert_nop;
         if (!nop_reg) begin
            rem_reg                        <= rem_reg - 16'd1;
            idx_reg                        <= idx_adv;
            retire_cnt_reg                 <= retire_cnt_reg + 32'd1;
            cls_cnt_reg[class_of(idx_reg)] <= cls_cnt_reg[class_of(idx_reg)] + 32'd1;
            nop_cnt_reg                    <= insert_nop ? 16'd0 : nop_cnt_reg + 16'd1;
         end
         if (last_retire) begin
            valid_reg <= 1'b0;
            instr_reg <= '0;
         end else if (insert_nop) begin
            instr_reg <= NOP_INSTR;
         end else begin
            instr_reg <= build_instr(class_opcode(launch_idx), lfsr_state);
         end
      end
   end

   assign valid_wb_o   = valid_reg;
   assign instr_wb_o   = instr_reg;
   assign exp_retire_o = retire_cnt_reg;
   assign exp_alu_o    = cls_cnt_reg[CLS_ALU];
   assign exp_branch_o = cls_cnt_reg[CLS_BRANCH];
   assign exp_load_o   = cls_cnt_reg[CLS_LOAD];
   assign exp_store_o  = cls_cnt_reg[CLS_STORE];

endmodule

// File: tb/tb_retire_stream_gen.sv
// Self-checking bench for retire_stream_gen: table-driven runs, random runs
// against a queue-based reference model, and reset / start-while-busy sequences.
module tb_retire_stream_gen;

`ifdef RETIRE_GEN_NOP_EN
   localparam bit TB_NOP_EN = 1'b1;
`else
   localparam bit TB_NOP_EN = 1'b0;
`endif
   localparam int TB_NOP_PERIOD = 8;
   localparam int NOP_X = TB_NOP_EN ? 1 : 0;

   logic        clk;
   logic        reset_ni;
   logic        start_i;
   logic [15:0] num_instr_i;
   logic [15:0] stall_seed_i;
   logic [3:0]  stall_thresh_i;
   logic        valid_wb_o, stall_wb_o, busy_o, done_o;
   logic [31:0] instr_wb_o;
   logic [31:0] exp_retire_o, exp_alu_o, exp_branch_o, exp_load_o, exp_store_o;

   int pass_cnt  = 0;
   int total_cnt = 0;

   typedef struct {
      int          num;
      logic [15:0] seed;
      logic [3:0]  thresh;
      int          e_ret, e_alu, e_br, e_ld, e_st;
      int          e_valid;
   } vec_t;

   vec_t vecs [6];

   retire_stream_gen #(
      .NOP_PERIOD        (TB_NOP_PERIOD),
      .LFSR_DEFAULT_SEED (16'hACE1)
   ) dut (
      .clk_i          (clk),
      .reset_ni       (reset_ni),
      .start_i        (start_i),
      .num_instr_i    (num_instr_i),
      .stall_seed_i   (stall_seed_i),
      .stall_thresh_i (stall_thresh_i),
      .valid_wb_o     (valid_wb_o),
      .stall_wb_o     (stall_wb_o),
      .instr_wb_o     (instr_wb_o),
      .busy_o         (busy_o),
      .done_o         (done_o),
      .exp_retire_o   (exp_retire_o),
      .exp_alu_o      (exp_alu_o),
      .exp_branch_o   (exp_branch_o),
      .exp_load_o     (exp_load_o),
      .exp_store_o    (exp_store_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #900000;
      $display("FAIL watchdog: simulation did not finish, got running expected finished");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   function automatic logic [15:0] lfsr_step(input logic [15:0] l);
      return l[0] ? ((l >> 1) ^ 16'hB400) : (l >> 1);
   endfunction

   function automatic logic [6:0] op_of(input int i);
      case (i % 9)
         0: return 7'b0110011;
         1: return 7'b0010011;
         2: return 7'b0010111;
         3: return 7'b0110111;
         4: return 7'b1100011;
         5: return 7'b1101111;
         6: return 7'b1100111;
         7: return 7'b0000011;
         default: return 7'b0100011;
      endcase
   endfunction

   // Class totals for the first n entries of the 9-entry table sequence.
   function automatic vec_t expected_counts(input int n, input logic [15:0] seed, input logic [3:0] thresh);
      vec_t v;
      int full, r;
      full = n / 9;
      r    = n % 9;
      v.num = n; v.seed = seed; v.thresh = thresh;
      v.e_ret = n;
      v.e_alu = 4 * full + ((r < 4) ? r : 4);
      v.e_br  = 3 * full + ((r <= 4) ? 0 : ((r >= 7) ? 3 : r - 4));
      v.e_ld  = full + ((r >= 8) ? 1 : 0);
      v.e_st  = full;
      v.e_valid = -1;
      return v;
   endfunction

   task automatic check_all_zero(input string name);
      check({name, "_ctrl"}, {28'd0, valid_wb_o, stall_wb_o, busy_o, done_o, instr_wb_o}, 64'd0);
      check({name, "_exp_retire"}, {32'd0, exp_retire_o}, 64'd0);
      check({name, "_exp_alu"},    {32'd0, exp_alu_o},    64'd0);
      check({name, "_exp_branch"}, {32'd0, exp_branch_o}, 64'd0);
      check({name, "_exp_load"},   {32'd0, exp_load_o},   64'd0);
      check({name, "_exp_store"},  {32'd0, exp_store_o},  64'd0);
   endtask

   task automatic run_and_check(input vec_t v, input bit glitch);
      int          q[$];
      logic [15:0] l;
      logic [24:0] upper;
      logic        exp_stall;
      logic [31:0] exp_instr;
      int          cyc, budget, dut_valid, dut_ret, dut_stall, mdl_stall;
      bit          timed_out;
      cyc = 0; dut_valid = 0; dut_ret = 0; dut_stall = 0; mdl_stall = 0; timed_out = 0;
      for (int i = 0; i < v.num; i++) begin
         q.push_back(i);
         if (TB_NOP_EN && ((i + 1) % TB_NOP_PERIOD == 0) && i != v.num - 1) q.push_back(-1);
      end
      @(negedge clk);
      num_instr_i = 16'(v.num); stall_seed_i = v.seed; stall_thresh_i = v.thresh; start_i = 1'b1;
      @(negedge clk);
      start_i = 1'b0;
      num_instr_i = 16'($urandom); stall_seed_i = 16'($urandom); stall_thresh_i = 4'($urandom);
      l      = (v.seed == 16'h0000) ? 16'hACE1 : v.seed;
      upper  = {l[8:0], l};
      budget = 64 * (v.num + 2) + 64;
      while (q.size() > 0 && !timed_out) begin
         exp_stall = (l[3:0] < v.thresh);
         exp_instr = (q[0] < 0) ? 32'h00000013 : {upper, op_of(q[0])};
         check("cycle", {28'd0, valid_wb_o, stall_wb_o, busy_o, done_o, instr_wb_o},
               {28'd0, 1'b1, exp_stall, 1'b1, 1'b0, exp_instr});
         dut_valid += int'(valid_wb_o);
         dut_stall += int'(stall_wb_o);
         mdl_stall += int'(exp_stall);
         if (valid_wb_o && !stall_wb_o && instr_wb_o != 32'h00000013) dut_ret++;
         start_i = glitch && (cyc == 2);
         if (start_i) num_instr_i = 16'd3;
         if (!exp_stall) begin
            void'(q.pop_front());
            upper = {l[8:0], l};
         end
         l = lfsr_step(l);
         cyc++;
         if (cyc > budget) begin
            total_cnt++;
            $display("FAIL timeout: got %0d cycles without finishing, expected at most %0d", cyc, budget);
            timed_out = 1'b1;
         end
         @(negedge clk);
      end
      start_i = 1'b0;
      check("done_cycle", {60'd0, valid_wb_o, stall_wb_o, busy_o, done_o}, 64'b0001);
      @(negedge clk);
      check("idle_after", {60'd0, valid_wb_o, stall_wb_o, busy_o, done_o}, 64'd0);
      check("exp_retire", {32'd0, exp_retire_o}, 64'(v.e_ret));
      check("exp_alu",    {32'd0, exp_alu_o},    64'(v.e_alu));
      check("exp_branch", {32'd0, exp_branch_o}, 64'(v.e_br));
      check("exp_load",   {32'd0, exp_load_o},   64'(v.e_ld));
      check("exp_store",  {32'd0, exp_store_o},  64'(v.e_st));
      check("retire_count", 64'(dut_ret), 64'(v.e_ret));
      check("stall_count",  64'(dut_stall), 64'(mdl_stall));
      if (v.e_valid >= 0) check("valid_cycles", 64'(dut_valid), 64'(v.e_valid));
      $display("run num=%0d seed=%h thresh=%0d glitch=%0d cycles=%0d stalls=%0d retired=%0d",
               v.num, v.seed, v.thresh, glitch, cyc, dut_stall, dut_ret);
   endtask

   initial begin
      vecs[0] = '{9,  16'hACE1, 4'd0,  9,  4,  3, 1, 1, 9 + NOP_X};
      vecs[1] = '{20, 16'h1234, 4'd12, 20, 10, 6, 2, 2, -1};
      vecs[2] = '{0,  16'h5555, 4'd7,  0,  0,  0, 0, 0, 0};
      vecs[3] = '{1,  16'h0000, 4'd0,  1,  1,  0, 0, 0, 1};
      vecs[4] = '{13, 16'hBEEF, 4'd5,  13, 8,  3, 1, 1, -1};
      vecs[5] = '{17, 16'h0001, 4'd15, 17, 8,  6, 2, 1, -1};

      reset_ni = 1'b0; start_i = 1'b0;
      num_instr_i = '0; stall_seed_i = '0; stall_thresh_i = '0;
      repeat (2) @(negedge clk);
      check_all_zero("reset");
      reset_ni = 1'b1;

      for (int r = 0; r < 6; r++) run_and_check(vecs[r], 1'b0);

      // Reset in the middle of a long run, then confirm a silent idle cycle.
      @(negedge clk);
      num_instr_i = 16'd50; stall_seed_i = 16'h2468; stall_thresh_i = 4'd3; start_i = 1'b1;
      @(negedge clk);
      start_i = 1'b0;
      repeat (20) @(negedge clk);
      check("midrun_busy", {63'd0, busy_o}, 64'd1);
      reset_ni = 1'b0;
      @(negedge clk);
      check_all_zero("reset_mid");
      reset_ni = 1'b1;
      @(negedge clk);
      check_all_zero("post_reset");
      run_and_check(vecs[0], 1'b0);

      // start_i pulsed while busy must not disturb the run.
      run_and_check(expected_counts(12, 16'h7A5C, 4'd4), 1'b1);

      for (int r = 0; r < 8; r++) begin
         int n;
         n = int'($urandom_range(0, 40));
         run_and_check(expected_counts(n, 16'($urandom), 4'($urandom_range(0, 15))),
                       (n >= 4) && ($urandom_range(0, 1) == 1));
      end

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
